// File: rtl/adc_acq_pkg.sv
// rtl/adc_acq_pkg.sv - shared states, word tags and default widths for the acquisition sequencer
package adc_acq_pkg;

    localparam int BURST_W_DEF = 23;
    localparam int WFM_W_DEF   = 12;
    localparam int GAP_W_DEF   = 22;

    // Tags identifying which word the downstream mux emits
    localparam logic [2:0] TAG_FILL_HDR = 3'd1;
    localparam logic [2:0] TAG_WFM_HDR  = 3'd2;
    localparam logic [2:0] TAG_DATA     = 3'd3;
    localparam logic [2:0] TAG_CHECKSUM = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL_HDR,
        S_WFM_HDR,
        S_DATA,
        S_POST_DATA,
        S_GAP,
        S_CHECKSUM,
        S_DONE
    } state_t;

endpackage

// File: rtl/adc_acq_sequencer_if.sv
// rtl/adc_acq_sequencer_if.sv - control, config, mux-select and FIFO strobe bundle
interface adc_acq_sequencer_if #(
    parameter int BURST_W = 23,
    parameter int WFM_W   = 12,
    parameter int GAP_W   = 22
);
    logic               acq_enable;
    logic               trigger;
    logic [BURST_W-1:0] num_fill_bursts;
    logic [WFM_W-1:0]   num_waveforms;
    logic [GAP_W-1:0]   waveform_gap;
    logic               fifo_full;
    logic               select_fill_hdr;
    logic               select_waveform_hdr;
    logic               select_dat;
    logic               select_checksum;
    logic               checksum_update;
    logic [WFM_W-1:0]   current_waveform_num;
    logic               fifo_wr_en;
    logic               acq_busy;
    logic               acq_done;
    logic               missed_trigger;
    logic               overflow;

    // Sequencer side: consumes control/config, drives mux selects and strobes
    modport master (
        input  acq_enable, trigger, num_fill_bursts, num_waveforms, waveform_gap, fifo_full,
        output select_fill_hdr, select_waveform_hdr, select_dat, select_checksum,
               checksum_update, current_waveform_num, fifo_wr_en,
               acq_busy, acq_done, missed_trigger, overflow
    );

    // Controller / mux side
    modport slave (
        output acq_enable, trigger, num_fill_bursts, num_waveforms, waveform_gap, fifo_full,
        input  select_fill_hdr, select_waveform_hdr, select_dat, select_checksum,
               checksum_update, current_waveform_num, fifo_wr_en,
               acq_busy, acq_done, missed_trigger, overflow
    );
endinterface

// File: rtl/adc_acq_sequencer.sv
// rtl/adc_acq_sequencer.sv - per-channel fill sequencer driving tagged-word mux selects and FIFO write
module adc_acq_sequencer
    import adc_acq_pkg::*;
#(
    parameter int BURST_W = BURST_W_DEF,
    parameter int WFM_W   = WFM_W_DEF,
    parameter int GAP_W   = GAP_W_DEF
) (
    input logic             clk,
    input logic             reset,
    adc_acq_sequencer_if.master bus
);

    state_t             state;
    state_t             next_state;

    logic [BURST_W-1:0] bursts_q;
    logic [WFM_W-1:0]   wfm_last_q;
    logic [GAP_W-1:0]   gap_q;
    logic [BURST_W-1:0] burst_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [WFM_W-1:0]   wfm_num;

    logic sel_fill_q, sel_wfm_q, sel_dat_q, sel_chk_q;
    logic cks_upd_q, wr_en_q, busy_q, done_q, missed_q, ovf_q;

    logic accept;
    logic wfm_is_last;

    assign accept      = (state == S_IDLE) && bus.trigger && bus.acq_enable;
    assign wfm_is_last = (wfm_num == wfm_last_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state decode; counters hold the remaining length of the current phase
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (accept) next_state = S_FILL_HDR;
            S_FILL_HDR:  next_state = S_WFM_HDR;
            S_WFM_HDR:   next_state = (bursts_q == '0) ? S_POST_DATA : S_DATA;
            S_DATA:      if (burst_cnt == BURST_W'(1)) next_state = S_POST_DATA;
            S_POST_DATA: begin
                if (wfm_is_last)      next_state = S_CHECKSUM;
                else if (gap_q != '0) next_state = S_GAP;
                else                  next_state = S_WFM_HDR;
            end
            S_GAP:       if (gap_cnt == GAP_W'(1)) next_state = S_WFM_HDR;
            S_CHECKSUM:  next_state = S_DONE;
            S_DONE:      next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Config latch on acceptance, burst/gap down-counters and waveform index
    always_ff @(posedge clk) begin
        if (reset) begin
            bursts_q   <= '0;
            wfm_last_q <= '0;
            gap_q      <= '0;
            burst_cnt  <= '0;
            gap_cnt    <= '0;
            wfm_num    <= '0;
        end else begin
            if (accept) begin
                bursts_q   <= bus.num_fill_bursts;
                wfm_last_q <= (bus.num_waveforms == '0) ? '0 : bus.num_waveforms - WFM_W'(1);
                gap_q      <= bus.waveform_gap;
                wfm_num    <= '0;
            end
            if (state == S_WFM_HDR)   burst_cnt <= bursts_q;
            else if (state == S_DATA) burst_cnt <= burst_cnt - BURST_W'(1);
            if (state == S_POST_DATA && !wfm_is_last) begin
                wfm_num <= wfm_num + WFM_W'(1);
                gap_cnt <= gap_q;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // Registered Moore outputs aligned with the state; write strobe trails selects by one clk
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_fill_q <= 1'b0;
            sel_wfm_q  <= 1'b0;
            sel_dat_q  <= 1'b0;
            sel_chk_q  <= 1'b0;
            cks_upd_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            missed_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            sel_fill_q <= (next_state == S_FILL_HDR);
            sel_wfm_q  <= (next_state == S_WFM_HDR);
            sel_dat_q  <= (next_state == S_DATA);
            sel_chk_q  <= (next_state == S_CHECKSUM);
            cks_upd_q  <= (next_state == S_DATA);
            busy_q     <= (next_state != S_IDLE);
            done_q     <= (next_state == S_DONE);
            wr_en_q    <= sel_fill_q | sel_wfm_q | sel_dat_q | sel_chk_q;
            missed_q   <= bus.trigger && (state != S_IDLE);
            ovf_q      <= ovf_q | (wr_en_q & bus.fifo_full);
        end
    end

    assign bus.select_fill_hdr      = sel_fill_q;
    assign bus.select_waveform_hdr  = sel_wfm_q;
    assign bus.select_dat           = sel_dat_q;
    assign bus.select_checksum      = sel_chk_q;
    assign bus.checksum_update      = cks_upd_q;
    assign bus.current_waveform_num = wfm_num;
    assign bus.fifo_wr_en           = wr_en_q;
    assign bus.acq_busy             = busy_q;
    assign bus.acq_done             = done_q;
    assign bus.missed_trigger       = missed_q;
    assign bus.overflow             = ovf_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// tb/tb_adc_acq_sequencer.sv - self-checking bench for adc_acq_sequencer
module tb_adc_acq_sequencer;
    import adc_acq_pkg::*;

    localparam int BW = 23;
    localparam int WW = 12;
    localparam int GW = 22;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    adc_acq_sequencer_if #(.BURST_W(BW), .WFM_W(WW), .GAP_W(GW)) bus();
    adc_acq_sequencer #(.BURST_W(BW), .WFM_W(WW), .GAP_W(GW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit exp_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    int  rec_tag[$];
    int  rec_cyc[$];
    int  rec_wfm[$];
    int  rec_done[$];
    int  missed_cnt = 0;
    int  wr_cnt = 0;
    int  inv_err = 0;
    bit  prev_sel = 1'b0;

    // Observe every cycle: record emitted words and count invariant violations
    always @(negedge clk) begin
        int nsel;
        if (reset) begin
            prev_sel = 1'b0;
        end else begin
            nsel = int'(bus.select_fill_hdr) + int'(bus.select_waveform_hdr)
                 + int'(bus.select_dat) + int'(bus.select_checksum);
            if (nsel > 1) inv_err++;
            if (bus.fifo_wr_en !== prev_sel) inv_err++;
            if (bus.checksum_update !== bus.select_dat) inv_err++;
            if (nsel != 0 && bus.acq_busy !== 1'b1) inv_err++;
            if (nsel != 0) begin
                if (bus.select_fill_hdr)          rec_tag.push_back(int'(TAG_FILL_HDR));
                else if (bus.select_waveform_hdr) rec_tag.push_back(int'(TAG_WFM_HDR));
                else if (bus.select_dat)          rec_tag.push_back(int'(TAG_DATA));
                else                              rec_tag.push_back(int'(TAG_CHECKSUM));
                rec_cyc.push_back(cyc);
                rec_wfm.push_back(int'(bus.current_waveform_num));
            end
            if (bus.acq_done) rec_done.push_back(cyc);
            if (bus.missed_trigger) missed_cnt++;
            if (bus.fifo_wr_en) wr_cnt++;
            prev_sel = (nsel != 0);
        end
    end

    function automatic logic [21:0] outs();
        return {bus.select_fill_hdr, bus.select_waveform_hdr, bus.select_dat, bus.select_checksum,
                bus.checksum_update, bus.current_waveform_num, bus.fifo_wr_en, bus.acq_busy,
                bus.acq_done, bus.missed_trigger, bus.overflow};
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        rec_tag.delete(); rec_cyc.delete(); rec_wfm.delete(); rec_done.delete();
    endtask

    // Run one fill and compare against a word-list model built from the fill rules
    task automatic do_fill(input int b, input int w, input int g,
                           input bit md, input bit mdone, input bit ovf);
        int et[$]; int ec[$]; int ew[$];
        int trig, t, weff, exp_done, m0, w0, bad_tag, bad_cyc, bad_wfm, n;
        bit got_done, did_md, did_ovf;
        clear_rec();
        m0 = missed_cnt; w0 = wr_cnt;
        got_done = 0; did_md = 0; did_ovf = 0;
        @(negedge clk);
        bus.num_fill_bursts = BW'(b);
        bus.num_waveforms   = WW'(w);
        bus.waveform_gap    = GW'(g);
        bus.trigger = 1'b1;
        trig = cyc;
        @(negedge clk);
        bus.trigger = 1'b0;
        bus.num_fill_bursts = BW'($urandom_range(1, 9));
        bus.num_waveforms   = WW'($urandom_range(1, 9));
        bus.waveform_gap    = GW'($urandom_range(1, 9));
        for (int k = 0; k < 4000 && !got_done; k++) begin
            @(negedge clk);
            bus.trigger = 1'b0;
            bus.fifo_full = 1'b0;
            if (ovf && !did_ovf && bus.fifo_wr_en) begin
                bus.fifo_full = 1'b1;
                did_ovf = 1;
                exp_ovf = 1'b1;
            end
            if (bus.acq_done) begin
                got_done = 1;
                if (mdone) bus.trigger = 1'b1;
            end else if (md && !did_md && bus.select_dat) begin
                bus.trigger = 1'b1;
                did_md = 1;
            end
        end
        @(negedge clk);
        bus.trigger = 1'b0;
        bus.fifo_full = 1'b0;
        @(negedge clk);
        chk("done_seen", got_done, 1);

        weff = (w == 0) ? 1 : w;
        t = trig + 1;
        et.push_back(1); ec.push_back(t); ew.push_back(0);
        for (int i = 0; i < weff; i++) begin
            t++; et.push_back(2); ec.push_back(t); ew.push_back(i);
            for (int j = 0; j < b; j++) begin
                t++; et.push_back(3); ec.push_back(t); ew.push_back(i);
            end
            t++;
            if (i < weff - 1) t += g;
            else begin
                t++; et.push_back(4); ec.push_back(t); ew.push_back(i);
            end
        end
        exp_done = t + 1;

        chk("word_count", rec_tag.size(), et.size());
        chk("closed_form_count", rec_tag.size(), 2 + weff * (1 + b));
        n = (rec_tag.size() < et.size()) ? rec_tag.size() : et.size();
        bad_tag = 0; bad_cyc = 0; bad_wfm = 0;
        for (int i = 0; i < n; i++) begin
            if (rec_tag[i] != et[i]) bad_tag++;
            if (rec_cyc[i] != ec[i]) bad_cyc++;
            if (rec_wfm[i] != ew[i]) bad_wfm++;
        end
        chk("word_tag_mismatches", bad_tag, 0);
        chk("word_cycle_mismatches", bad_cyc, 0);
        chk("waveform_num_mismatches", bad_wfm, 0);
        chk("done_count", rec_done.size(), 1);
        if (rec_done.size() > 0) chk("done_cycle", rec_done[0], exp_done);
        chk("missed_pulses", missed_cnt - m0, int'(md && b > 0) + int'(mdone));
        chk("fifo_wr_count", wr_cnt - w0, et.size());
        chk("invariant_violations", inv_err, 0);
        chk("busy_after_fill", bus.acq_busy, 0);
        chk("overflow", bus.overflow, exp_ovf);
    endtask

    initial begin
        int m0;
        bit seen;
        reset = 1'b1;
        bus.acq_enable = 1'b1;
        bus.trigger = 1'b0;
        bus.fifo_full = 1'b0;
        bus.num_fill_bursts = '0;
        bus.num_waveforms = '0;
        bus.waveform_gap = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        do_fill(4, 1, 0, 0, 0, 0);
        do_fill(2, 3, 5, 0, 0, 0);
        do_fill(0, 0, 3, 0, 0, 0);
        do_fill(1, 2, 0, 0, 0, 0);
        do_fill(5, 2, 2, 1, 1, 0);

        // Disabled: trigger must be silently ignored
        clear_rec();
        m0 = missed_cnt;
        @(negedge clk);
        bus.acq_enable = 1'b0;
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        repeat (20) @(negedge clk);
        chk("disabled_words", rec_tag.size(), 0);
        chk("disabled_missed", missed_cnt - m0, 0);
        chk("disabled_busy", bus.acq_busy, 0);
        bus.acq_enable = 1'b1;

        do_fill(3, 2, 1, 0, 0, 1);
        do_fill(2, 1, 0, 0, 0, 0);

        for (int r = 0; r < 4; r++) begin
            do_fill(int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 5)), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)), 1'b0);
        end

        // Reset in the middle of a data burst
        clear_rec();
        @(negedge clk);
        bus.num_fill_bursts = BW'(8);
        bus.num_waveforms = WW'(2);
        bus.waveform_gap = GW'(1);
        bus.trigger = 1'b1;
        @(negedge clk);
        bus.trigger = 1'b0;
        seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (bus.select_dat) seen = 1;
        end
        chk("reached_data", seen, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_outputs", outs(), 0);
        exp_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("no_checksum_after_reset", rec_tag.size() == 0 ? 0 : int'(rec_tag[rec_tag.size()-1] == int'(TAG_CHECKSUM)), 0);
        @(negedge clk);
        do_fill(3, 2, 2, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
